// File: rtl/hilo_pipe.sv
// hilo_pipe
// ---------
// Carries HI/LO write requests from EX through the MEM and WB pipeline
// registers, commits them to the architected HI/LO pair, and returns every
// in-flight level to EX for forwarding. It follows the same stall/flush
// controls as the main EX/MEM and MEM/WB registers.
//
// Ports
//   clk            : rising-edge clock
//   rst            : asynchronous reset, active low
//   ex_hi_i/lo_i   : HI/LO pair produced by EX
//   ex_whilo_i     : EX requests a HI/LO write (pair always written whole)
//   stall_i[2:0]   : stage stalls, bit0 = EX, bit1 = MEM, bit2 = WB
//   flush_i        : discard the MEM and WB entries
//   mem_*_o        : MEM-stage entry
//   wb_*_o         : WB-stage entry
//   hi_o/lo_o      : architected HI/LO
//   fwd_hi_o/lo_o  : newest visible HI/LO (MEM, then WB, then ARCH)
//   commit_cnt_o   : number of committed writes, wraps at 256
module hilo_pipe #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] ex_hi_i,
   input  logic [DW-1:0] ex_lo_i,
   input  logic          ex_whilo_i,
   input  logic [2:0]    stall_i,
   input  logic          flush_i,
   output logic [DW-1:0] mem_hi_o,
   output logic [DW-1:0] mem_lo_o,
   output logic          mem_whilo_o,
   output logic [DW-1:0] wb_hi_o,
   output logic [DW-1:0] wb_lo_o,
   output logic          wb_whilo_o,
   output logic [DW-1:0] hi_o,
   output logic [DW-1:0] lo_o,
   output logic [DW-1:0] fwd_hi_o,
   output logic [DW-1:0] fwd_lo_o,
   output logic [7:0]    commit_cnt_o
);

   logic [DW-1:0] mem_hi_q, mem_hi_d;
   logic [DW-1:0] mem_lo_q, mem_lo_d;
   logic          mem_whilo_q, mem_whilo_d;
   logic [DW-1:0] wb_hi_q, wb_hi_d;
   logic [DW-1:0] wb_lo_q, wb_lo_d;
   logic          wb_whilo_q, wb_whilo_d;
   logic [DW-1:0] arch_hi_q, arch_hi_d;
   logic [DW-1:0] arch_lo_q, arch_lo_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          commit;

   // ---- EX -> MEM boundary ----
   // Priority: flush, bubble (EX stalled but MEM free), advance, hold.
   always_comb begin
      mem_hi_d    = mem_hi_q;
      mem_lo_d    = mem_lo_q;
      mem_whilo_d = mem_whilo_q;
      if (flush_i || (stall_i[0] && !stall_i[1])) begin
         mem_hi_d    = '0;
         mem_lo_d    = '0;
         mem_whilo_d = 1'b0;
      end else if (!stall_i[0]) begin
         mem_hi_d    = ex_hi_i;
         mem_lo_d    = ex_lo_i;
         mem_whilo_d = ex_whilo_i;
      end
   end

   // ---- MEM -> WB boundary ----
   always_comb begin
      wb_hi_d    = wb_hi_q;
      wb_lo_d    = wb_lo_q;
      wb_whilo_d = wb_whilo_q;
      if (flush_i || (stall_i[1] && !stall_i[2])) begin
         wb_hi_d    = '0;
         wb_lo_d    = '0;
         wb_whilo_d = 1'b0;
      end else if (!stall_i[1]) begin
         wb_hi_d    = mem_hi_q;
         wb_lo_d    = mem_lo_q;
         wb_whilo_d = mem_whilo_q;
      end
   end

   // ---- WB -> ARCH boundary ----
   // Flush does not block this: an entry already in WB retires on a flush edge.
   assign commit = wb_whilo_q && !stall_i[2];

   always_comb begin
      arch_hi_d = arch_hi_q;
      arch_lo_d = arch_lo_q;
      cnt_d     = cnt_q;
      if (commit) begin
         arch_hi_d = wb_hi_q;
         arch_lo_d = wb_lo_q;
         cnt_d     = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_hi_q    <= '0;
         mem_lo_q    <= '0;
         mem_whilo_q <= 1'b0;
         wb_hi_q     <= '0;
         wb_lo_q     <= '0;
         wb_whilo_q  <= 1'b0;
         arch_hi_q   <= '0;
         arch_lo_q   <= '0;
         cnt_q       <= '0;
      end else begin
         mem_hi_q    <= mem_hi_d;
         mem_lo_q    <= mem_lo_d;
         mem_whilo_q <= mem_whilo_d;
         wb_hi_q     <= wb_hi_d;
         wb_lo_q     <= wb_lo_d;
         wb_whilo_q  <= wb_whilo_d;
         arch_hi_q   <= arch_hi_d;
         arch_lo_q   <= arch_lo_d;
         cnt_q       <= cnt_d;
      end
   end

   assign mem_hi_o     = mem_hi_q;
   assign mem_lo_o     = mem_lo_q;
   assign mem_whilo_o  = mem_whilo_q;
   assign wb_hi_o      = wb_hi_q;
   assign wb_lo_o      = wb_lo_q;
   assign wb_whilo_o   = wb_whilo_q;
   assign hi_o         = arch_hi_q;
   assign lo_o         = arch_lo_q;
   assign commit_cnt_o = cnt_q;

   // MEM is newer than WB, so it wins when both hold a write.
   always_comb begin
      fwd_hi_o = arch_hi_q;
      fwd_lo_o = arch_lo_q;
      if (mem_whilo_q) begin
         fwd_hi_o = mem_hi_q;
         fwd_lo_o = mem_lo_q;
      end else if (wb_whilo_q) begin
         fwd_hi_o = wb_hi_q;
         fwd_lo_o = wb_lo_q;
      end
   end

endmodule
